// File: rtl/player_move_ctrl.sv
// Player A/B position controller for the 10x6 tile grid.
// Keyboard moves are queued per player and committed only on frame ticks.
module player_move_ctrl #(
   parameter int unsigned MOVE_FRAMES = 4,
   parameter int unsigned A_INIT_H    = 1,
   parameter int unsigned A_INIT_V    = 1,
   parameter int unsigned B_INIT_H    = 8,
   parameter int unsigned B_INIT_V    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       key_valid,
   input  logic       key_player,
   input  logic [1:0] key_dir,
   output logic [3:0] curAh,
   output logic [3:0] curAv,
   output logic [3:0] curBh,
   output logic [3:0] curBv,
   output logic [1:0] move_ack,
   output logic [1:0] bump
);

   localparam logic [3:0] CD_LOAD = 4'(MOVE_FRAMES - 1);

   logic       pend_a, pend_b;
   logic [1:0] dir_a, dir_b;
   logic [3:0] cd_a, cd_b;

   logic [4:0] a_th, a_tv, b_th, b_tv;
   logic       a_go, b_go, a_acc, b_acc;
   logic [3:0] a_nh, a_nv;

   // Target tile, 5 bits wide so that 0-1 lands out of range instead of wrapping.
   function automatic logic [9:0] next_tile(input logic [3:0] h, input logic [3:0] v,
                                            input logic [1:0] d);
      logic [4:0] th, tv;
      th = {1'b0, h};
      tv = {1'b0, v};
      case (d)
         2'b00:   tv = tv - 5'd1;
         2'b01:   tv = tv + 5'd1;
         2'b10:   th = th - 5'd1;
         default: th = th + 5'd1;
      endcase
      return {th, tv};
   endfunction

   function automatic logic legal(input logic [4:0] th, input logic [4:0] tv);
      return (th <= 5'd9) && (tv <= 5'd5) &&
             !(((th % 5'd3) != 5'd0) && (tv[1:0] == 2'b00));
   endfunction

   // A commits first; B then checks against A's post-commit position.
   always_comb begin
      {a_th, a_tv} = next_tile(curAh, curAv, dir_a);
      a_go  = frame_tick && (cd_a == 4'd0) && pend_a;
      a_acc = a_go && legal(a_th, a_tv) &&
              !((a_th == {1'b0, curBh}) && (a_tv == {1'b0, curBv}));
      a_nh  = a_acc ? a_th[3:0] : curAh;
      a_nv  = a_acc ? a_tv[3:0] : curAv;

      {b_th, b_tv} = next_tile(curBh, curBv, dir_b);
      b_go  = frame_tick && (cd_b == 4'd0) && pend_b;
      b_acc = b_go && legal(b_th, b_tv) &&
              !((b_th == {1'b0, a_nh}) && (b_tv == {1'b0, a_nv}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         curAh    <= 4'(A_INIT_H);
         curAv    <= 4'(A_INIT_V);
         curBh    <= 4'(B_INIT_H);
         curBv    <= 4'(B_INIT_V);
         move_ack <= 2'b00;
         bump     <= 2'b00;
         pend_a   <= 1'b0;
         pend_b   <= 1'b0;
         dir_a    <= 2'b00;
         dir_b    <= 2'b00;
         cd_a     <= 4'd0;
         cd_b     <= 4'd0;
      end else begin
         move_ack <= {b_acc, a_acc};
         bump     <= {b_go & ~b_acc, a_go & ~a_acc};
         curAh    <= a_nh;
         curAv    <= a_nv;
         if (b_acc) begin
            curBh <= b_th[3:0];
            curBv <= b_tv[3:0];
         end

         if (frame_tick) begin
            if (cd_a != 4'd0) cd_a <= cd_a - 4'd1;
            else if (a_acc)   cd_a <= CD_LOAD;
            if (cd_b != 4'd0) cd_b <= cd_b - 4'd1;
            else if (b_acc)   cd_b <= CD_LOAD;
         end

         // A request arriving on a tick cycle is kept for the next tick.
         if (a_go) pend_a <= 1'b0;
         if (b_go) pend_b <= 1'b0;
         if (key_valid && !key_player) begin
            pend_a <= 1'b1;
            dir_a  <= key_dir;
         end
         if (key_valid && key_player) begin
            pend_b <= 1'b1;
            dir_b  <= key_dir;
         end
      end
   end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Bench for player_move_ctrl: directed vector table, corner sequences,
// and random traffic against a per-player reference model.
module tb_player_move_ctrl;

   localparam int MF = 4;
   localparam logic [1:0] UP = 2'd0, DN = 2'd1, LT = 2'd2, RT = 2'd3;

   logic       clk, rst, frame_tick, key_valid, key_player;
   logic [1:0] key_dir;
   logic [3:0] curAh, curAv, curBh, curBv;
   logic [1:0] move_ack, bump;

   player_move_ctrl #(.MOVE_FRAMES(MF)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .key_valid(key_valid),
      .key_player(key_player), .key_dir(key_dir),
      .curAh(curAh), .curAv(curAv), .curBh(curBh), .curBv(curBv),
      .move_ack(move_ack), .bump(bump)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: per-player arrays, index 0 = A, 1 = B.
   int         mh[2], mv[2], mcd[2], mdir[2];
   bit         mpend[2];
   logic [1:0] mack, mbump;

   typedef struct {
      logic       tick, kv, kp;
      logic [1:0] kd;
      int         ah, av, bh, bv;
      logic [1:0] ack, bmp;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(input logic t, input logic kv, input logic kp, input logic [1:0] kd,
                               input int ah, input int av, input int bh, input int bv,
                               input logic [1:0] ack, input logic [1:0] bmp);
      vec_t r;
      r.tick = t; r.kv = kv; r.kp = kp; r.kd = kd;
      r.ah = ah; r.av = av; r.bh = bh; r.bv = bv;
      r.ack = ack; r.bmp = bmp;
      return r;
   endfunction

   function automatic bit is_block(input int h, input int v);
      return (h % 3 != 0) && (v % 4 == 0);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mh[0] = 1; mv[0] = 1; mh[1] = 8; mv[1] = 5;
      for (int p = 0; p < 2; p++) begin
         mcd[p] = 0; mpend[p] = 0; mdir[p] = 0;
      end
      mack = 2'b00; mbump = 2'b00;
   endtask

   task automatic model_step(input logic t, input logic kv, input logic kp, input logic [1:0] kd);
      int th, tv;
      bit ok;
      mack = 2'b00; mbump = 2'b00;
      if (t) begin
         for (int p = 0; p < 2; p++) begin
            if (mcd[p] > 0) mcd[p]--;
            else if (mpend[p]) begin
               th = mh[p]; tv = mv[p];
               case (mdir[p])
                  0: tv = tv - 1;
                  1: tv = tv + 1;
                  2: th = th - 1;
                  default: th = th + 1;
               endcase
               ok = (th >= 0) && (th <= 9) && (tv >= 0) && (tv <= 5) &&
                    !is_block(th, tv) && !((th == mh[1-p]) && (tv == mv[1-p]));
               if (ok) begin
                  mh[p] = th; mv[p] = tv; mcd[p] = MF - 1; mack[p] = 1'b1;
               end else mbump[p] = 1'b1;
               mpend[p] = 0;
            end
         end
      end
      if (kv) begin
         mpend[kp] = 1;
         mdir[kp]  = int'(kd);
      end
   endtask

   task automatic compare_model();
      chk("model_Ah", int'(curAh), mh[0]);
      chk("model_Av", int'(curAv), mv[0]);
      chk("model_Bh", int'(curBh), mh[1]);
      chk("model_Bv", int'(curBv), mv[1]);
      chk("model_ack", int'(move_ack), int'(mack));
      chk("model_bump", int'(bump), int'(mbump));
   endtask

   task automatic cyc(input logic t, input logic kv, input logic kp, input logic [1:0] kd);
      frame_tick = t; key_valid = kv; key_player = kp; key_dir = kd;
      model_step(t, kv, kp, kd);
      @(posedge clk);
      #1;
      frame_tick = 1'b0; key_valid = 1'b0;
      compare_model();
   endtask

   task automatic mv_one(input logic p, input logic [1:0] d, output logic [1:0] a, output logic [1:0] b);
      cyc(1'b0, 1'b1, p, d);
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      a = move_ack; b = bump;
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 2'd0);
   endtask

   logic [1:0] ra, rb;
   logic [1:0] prev_pulse;
   logic       prev_tick;
   int         since_tick;

   initial begin
      rst = 1'b1; frame_tick = 1'b0; key_valid = 1'b0; key_player = 1'b0; key_dir = 2'd0;
      model_reset();
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;

      // Pending request issued, then reset mid-operation.
      cyc(1'b0, 1'b1, 1'b0, RT);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1; rst = 1'b0;
      model_reset();
      chk("rst_Ah", int'(curAh), 1);
      chk("rst_Av", int'(curAv), 1);
      chk("rst_Bh", int'(curBh), 8);
      chk("rst_Bv", int'(curBv), 5);
      chk("rst_ack", int'(move_ack), 0);
      chk("rst_bump", int'(bump), 0);
      cyc(1'b1, 1'b0, 1'b0, 2'd0);
      chk("rst_lost_pending", int'(curAh), 1);

      tbl[0]  = mk(0, 1, 0, RT, 1, 1, 8, 5, 2'b00, 2'b00);
      tbl[1]  = mk(1, 0, 0, UP, 2, 1, 8, 5, 2'b01, 2'b00);
      tbl[2]  = mk(0, 0, 0, UP, 2, 1, 8, 5, 2'b00, 2'b00);
      tbl[3]  = mk(0, 1, 0, RT, 2, 1, 8, 5, 2'b00, 2'b00);
      tbl[4]  = mk(1, 0, 0, UP, 2, 1, 8, 5, 2'b00, 2'b00);
      tbl[5]  = mk(1, 0, 0, UP, 2, 1, 8, 5, 2'b00, 2'b00);
      tbl[6]  = mk(1, 0, 0, UP, 2, 1, 8, 5, 2'b00, 2'b00);
      tbl[7]  = mk(1, 0, 0, UP, 3, 1, 8, 5, 2'b01, 2'b00);
      tbl[8]  = mk(0, 1, 0, RT, 3, 1, 8, 5, 2'b00, 2'b00);
      tbl[9]  = mk(1, 0, 0, UP, 3, 1, 8, 5, 2'b00, 2'b00);
      tbl[10] = mk(1, 0, 0, UP, 3, 1, 8, 5, 2'b00, 2'b00);
      tbl[11] = mk(1, 0, 0, UP, 3, 1, 8, 5, 2'b00, 2'b00);
      tbl[12] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b01, 2'b00);
      tbl[13] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[14] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[15] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[16] = mk(0, 1, 0, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[17] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b01);
      tbl[18] = mk(0, 1, 1, DN, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[19] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b10);
      tbl[20] = mk(0, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[21] = mk(0, 1, 1, UP, 4, 1, 8, 5, 2'b00, 2'b00);
      tbl[22] = mk(1, 0, 0, UP, 4, 1, 8, 5, 2'b00, 2'b10);

      for (int i = 0; i < 23; i++) begin
         cyc(tbl[i].tick, tbl[i].kv, tbl[i].kp, tbl[i].kd);
         chk($sformatf("vec%0d_Ah", i), int'(curAh), tbl[i].ah);
         chk($sformatf("vec%0d_Av", i), int'(curAv), tbl[i].av);
         chk($sformatf("vec%0d_Bh", i), int'(curBh), tbl[i].bh);
         chk($sformatf("vec%0d_Bv", i), int'(curBv), tbl[i].bv);
         chk($sformatf("vec%0d_ack", i), int'(move_ack), int'(tbl[i].ack));
         chk($sformatf("vec%0d_bump", i), int'(bump), int'(tbl[i].bmp));
      end

      // Left edge: walk A to column 0, then one more left must bump.
      repeat (4) begin
         mv_one(1'b0, LT, ra, rb);
         chk("walk_left_ack", int'(ra), 1);
      end
      chk("edge_Ah", int'(curAh), 0);
      mv_one(1'b0, LT, ra, rb);
      chk("edge_bump", int'(rb), 1);
      chk("edge_ack", int'(ra), 0);
      chk("edge_Ah_kept", int'(curAh), 0);

      // Position A at (4,2) and B at (5,3).
      mv_one(1'b0, DN, ra, rb);
      repeat (4) mv_one(1'b0, RT, ra, rb);
      mv_one(1'b1, LT, ra, rb);
      mv_one(1'b1, LT, ra, rb);
      mv_one(1'b1, UP, ra, rb);
      mv_one(1'b1, UP, ra, rb);
      mv_one(1'b1, LT, ra, rb);
      chk("setup_Ah", int'(curAh), 4);
      chk("setup_Av", int'(curAv), 2);
      chk("setup_Bh", int'(curBh), 5);
      chk("setup_Bv", int'(curBv), 3);

      // Both move into (4,3) on the same tick: A wins, B bumps.
      cyc(1'b0, 1'b1, 1'b0, DN);
      cyc(1'b0, 1'b1, 1'b1, LT);
      cyc(1'b1, 1'b0, 1'b0, UP);
      chk("coll_ack", int'(move_ack), 1);
      chk("coll_bump", int'(bump), 2);
      chk("coll_Av", int'(curAv), 3);
      chk("coll_Bh", int'(curBh), 5);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, UP);

      // Latest wins: down (BLOCK) overwritten by up.
      cyc(1'b0, 1'b1, 1'b0, DN);
      cyc(1'b0, 1'b1, 1'b0, UP);
      cyc(1'b1, 1'b0, 1'b0, UP);
      chk("latest_ack", int'(move_ack), 1);
      chk("latest_bump", int'(bump), 0);
      chk("latest_Av", int'(curAv), 2);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, UP);

      // Key coincident with tick is held until the following tick.
      cyc(1'b1, 1'b1, 1'b0, DN);
      chk("same_cyc_ack", int'(move_ack), 0);
      chk("same_cyc_Av", int'(curAv), 2);
      cyc(1'b1, 1'b0, 1'b0, UP);
      chk("next_tick_ack", int'(move_ack), 1);
      chk("next_tick_Av", int'(curAv), 3);

      // Random traffic with invariant checks.
      prev_pulse = 2'b00; prev_tick = 1'b1; since_tick = 0;
      for (int i = 0; i < 1000; i++) begin
         logic t;
         t = (since_tick >= 2) && ($urandom_range(0, 2) == 0);
         cyc(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
         since_tick = t ? 0 : since_tick + 1;
         if (curAh > 4'd9 || curAv > 4'd5 || is_block(int'(curAh), int'(curAv)))
            chk("rnd_A_legal", 0, 1);
         if (curBh > 4'd9 || curBv > 4'd5 || is_block(int'(curBh), int'(curBv)))
            chk("rnd_B_legal", 0, 1);
         chk("rnd_A_ne_B", int'((curAh == curBh) && (curAv == curBv)), 0);
         chk("rnd_ack_bump_excl", int'(move_ack & bump), 0);
         if (prev_pulse != 2'b00) chk("rnd_pulse_width", int'(move_ack | bump), 0);
         if (!t) chk("rnd_pulse_no_tick", int'(move_ack | bump), 0);
         prev_pulse = move_ack | bump;
         prev_tick = t;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
